ramp_adc_seq: RTL and testbench
===============================

Name: ramp_adc_seq

Overview:
Multi-channel conversion sequencer for the single-slope PWM ramp ADC core. It owns the analog input mux select and the ramp core's enable and clear controls. It walks a latched channel mask, applying a settle delay, a bounded conversion window and per-channel result capture. It sits between the register block (start/stop/config, result readback) and the ramp core plus its external analog mux.

Parameters:
NCH, 4, number of analog channels (2..16)
NBITS, 8, ADC result width; must match ramp core NBITS
SETTLE_W, 8, width of settle-delay count
TMO_W, 20, width of conversion timeout count

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  pulse: begin scan (honoured in IDLE only)
stop_i  in  1  pulse: abort scan
continuous_i  in  1  1 = wrap to first channel after last
chan_mask_i  in  NCH  enabled channels, latched on start
settle_i  in  SETTLE_W  mux settle cycles, latched on start
timeout_i  in  TMO_W  max CONVERT cycles, latched on start
ramp_en_o  out  1  enable to ramp core
ramp_clr_o  out  1  one-cycle clear pulse to ramp core (ORed into core reset by integration)
ramp_valid_i  in  1  ramp core conversion-valid pulse
ramp_value_i  in  NBITS  ramp core result
mux_sel_o  out  $clog2(NCH)  analog mux select
rd_ch_i  in  $clog2(NCH)  result readback index
rd_data_o  out  NBITS  stored result of rd_ch_i, registered (1-cycle latency)
res_valid_o  out  1  pulse: new result written
res_ch_o  out  $clog2(NCH)  channel of res_valid_o
tmo_flags_o  out  NCH  sticky per-channel timeout flags, cleared on accepted start
busy_o  out  1  1 when state != IDLE
done_o  out  1  pulse: single-shot scan complete

Behaviour:
- Reset: state IDLE; all outputs 0; result array 0; latched config 0.
- States: IDLE, SEEK, SETTLE, CONVERT, CAPTURE, GAP.
- IDLE: start_i with chan_mask_i != 0 -> latch mask/settle/timeout, clear tmo_flags_o, channel pointer = 0, go SEEK. start_i with mask 0 is ignored (no done_o).
- SEEK (1 cycle): pointer = lowest enabled index >= pointer; drive mux_sel_o; go SETTLE. If none remain: continuous -> pointer = lowest enabled index, go SETTLE; single-shot -> done_o pulse, go IDLE.
- SETTLE: ramp_en_o = 0; stays max(settle,1) cycles, then CONVERT.
- CONVERT: ramp_en_o = 1; cycle counter from 0. ramp_valid_i -> store ramp_value_i into result[pointer], go CAPTURE. Counter == timeout-1 without valid -> store all-ones, set tmo_flags_o[pointer], ramp_clr_o pulse, go CAPTURE. Valid and timeout in the same cycle: valid wins, no flag. timeout 0 is treated as 1.
- CAPTURE (1 cycle): ramp_en_o = 0; res_valid_o = 1, res_ch_o = pointer; go GAP.
- GAP (1 cycle, covers ramp core self-clear): pointer + 1 (wraps to 0 at NCH), go SEEK.
- stop_i in any non-IDLE state: next cycle IDLE; ramp_en_o = 0; ramp_clr_o pulse; no done_o; partial results kept. stop_i has priority over start_i.
- mux_sel_o is held stable from SEEK through GAP of a channel.
- ramp_valid_i outside CONVERT is ignored.
- Readback: rd_data_o <= result[rd_ch_i] every cycle; rd_ch_i >= NCH returns 0.

Optional Feature:
RAMP_ADC_SEQ_AVG_EN:
- Defined: each channel is converted 4 times back-to-back (SETTLE only before the first). An NBITS+2 accumulator sums the results (timeouts contribute all-ones). Stored value = sum >> 2. res_valid_o pulses once per channel, after the 4th conversion. Any timeout sets the flag.
- Undefined: single conversion per channel, no accumulator logic.

Test Plan:
- Mask 4'b0101, settle 3, timeout 1000, valid with value 0x5A after 20 CONVERT cycles on each channel -> mux_sel 0 then 2; res_valid on ch0 then ch2; rd_data(2) = 0x5A; one done_o; busy_o low after.
- Mask 4'b0010, timeout 50, no valid -> ramp_clr_o pulse at cycle 50 of CONVERT; result[1] = 0xFF; tmo_flags_o = 4'b0010; done_o.
- Valid and timeout coincide on cycle timeout-1 -> captured value stored, flag stays 0.
- continuous_i = 1, mask 4'b1001 -> sequence 0, 3, 0, 3...; no done_o; stop_i mid-CONVERT -> IDLE next cycle, ramp_en_o 0, ramp_clr_o pulse.
- start_i with mask 0 -> remains IDLE, busy_o 0, no done_o. Async reset asserted during CONVERT -> all outputs 0 immediately.
- AVG_EN: values 10, 11, 12, 13 on ch0 -> single res_valid_o, rd_data(0) = 11.

Source files
------------

// File: rtl/ramp_adc_seq.sv
// ramp_adc_seq: multi-channel conversion sequencer for the single-slope PWM ramp ADC core.
//
// Walks a channel mask that is latched on start. For each enabled channel it drives the analog
// mux select, waits a settle delay, enables the ramp core for a bounded conversion window and
// stores the result (or all-ones on timeout) in a per-channel result array for readback.
//
// Optional feature macro: RAMP_ADC_SEQ_AVG_EN
//   defined   : each channel is converted 4 times back-to-back and the stored value is the
//               average (sum >> 2); timeouts contribute all-ones to the sum.
//   undefined : single conversion per channel.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             pulse, begin a scan (honoured in IDLE only, mask must be non-zero)
//   stop_i              pulse, abort the scan (priority over start_i)
//   continuous_i        wrap to the first enabled channel after the last one
//   chan_mask_i         enabled channels (latched on start)
//   settle_i            mux settle cycles (latched on start, 0 behaves as 1)
//   timeout_i           max CONVERT cycles (latched on start, 0 behaves as 1)
//   ramp_en_o           ramp core enable
//   ramp_clr_o          one-cycle ramp core clear (timeout or abort)
//   ramp_valid_i        ramp core conversion-valid pulse
//   ramp_value_i        ramp core result
//   mux_sel_o           analog mux select
//   rd_ch_i, rd_data_o  result readback, one cycle latency, out-of-range index reads 0
//   res_valid_o         pulse, a result was written; res_ch_o is its channel
//   tmo_flags_o         sticky per-channel timeout flags, cleared on accepted start
//   busy_o              scan in progress
//   done_o              pulse, single-shot scan complete

module ramp_adc_seq #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned NBITS    = 8,
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned TMO_W    = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     continuous_i,
  input  logic [NCH-1:0]           chan_mask_i,
  input  logic [SETTLE_W-1:0]      settle_i,
  input  logic [TMO_W-1:0]         timeout_i,
  output logic                     ramp_en_o,
  output logic                     ramp_clr_o,
  input  logic                     ramp_valid_i,
  input  logic [NBITS-1:0]         ramp_value_i,
  output logic [$clog2(NCH)-1:0]   mux_sel_o,
  input  logic [$clog2(NCH)-1:0]   rd_ch_i,
  output logic [NBITS-1:0]         rd_data_o,
  output logic                     res_valid_o,
  output logic [$clog2(NCH)-1:0]   res_ch_o,
  output logic [NCH-1:0]           tmo_flags_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned CW = $clog2(NCH);

  typedef enum logic [2:0] {
    StIdle,
    StSeek,
    StSettle,
    StConvert,
    StCapture,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic [NCH-1:0]      mask_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [CW-1:0]       ptr_q;
  // Set when the pointer wrapped past the last channel, so SEEK sees "none remain".
  logic                end_q;
  logic [SETTLE_W-1:0] set_cnt_q;
  logic [TMO_W-1:0]    cvt_cnt_q;
  logic [NCH-1:0]      tmo_flags_q;
  logic [NBITS-1:0]    res_q [NCH];
  logic [NBITS-1:0]    rd_data_q;

  logic                seek_found;
  logic [CW-1:0]       seek_idx;
  logic [CW-1:0]       first_idx;
  logic [SETTLE_W-1:0] settle_eff;
  logic [TMO_W-1:0]    tmo_eff;
  logic                settle_last;
  logic                tmo_last;
  logic                abort;
  logic                start_ok;
  logic                in_cvt;
  logic                cvt_valid;
  logic                cvt_tmo;
  logic                cvt_end;
  logic [NBITS-1:0]    sample;
  logic                last_rep;
  logic [NBITS-1:0]    store_val;

  // Lowest enabled channel at or above the pointer, and lowest enabled channel overall.
  always_comb begin
    seek_found = 1'b0;
    seek_idx   = '0;
    first_idx  = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_idx = CW'(i);
        if (!end_q && (i >= int'(ptr_q))) begin
          seek_found = 1'b1;
          seek_idx   = CW'(i);
        end
      end
    end
  end

  always_comb begin
    settle_eff  = (settle_q == '0) ? SETTLE_W'(1) : settle_q;
    tmo_eff     = (tmo_q == '0) ? TMO_W'(1) : tmo_q;
    settle_last = (set_cnt_q == settle_eff - SETTLE_W'(1));
    tmo_last    = (cvt_cnt_q == tmo_eff - TMO_W'(1));
    abort       = (state_q != StIdle) && stop_i;
    start_ok    = (state_q == StIdle) && start_i && !stop_i && (chan_mask_i != '0);
    in_cvt      = (state_q == StConvert) && !stop_i;
    // A valid on the last allowed cycle wins over the timeout.
    cvt_valid   = in_cvt && ramp_valid_i;
    cvt_tmo     = in_cvt && !ramp_valid_i && tmo_last;
    cvt_end     = cvt_valid || cvt_tmo;
    sample      = ramp_valid_i ? ramp_value_i : '1;
  end

`ifdef RAMP_ADC_SEQ_AVG_EN
  logic [NBITS+1:0] acc_q;
  logic [NBITS+1:0] acc_sum;
  logic [1:0]       rep_q;

  always_comb begin
    acc_sum   = acc_q + {2'b00, sample};
    last_rep  = (rep_q == 2'd3);
    store_val = acc_sum[NBITS+1:2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      rep_q <= '0;
    end else if (state_q == StSeek) begin
      acc_q <= '0;
      rep_q <= '0;
    end else if (cvt_end) begin
      if (last_rep) begin
        acc_q <= '0;
        rep_q <= '0;
      end else begin
        acc_q <= acc_sum;
        rep_q <= rep_q + 2'd1;
      end
    end
  end
`else
  always_comb begin
    last_rep  = 1'b1;
    store_val = sample;
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_ok) state_d = StSeek;
      StSeek:    state_d = (seek_found || continuous_i) ? StSettle : StIdle;
      StSettle:  if (settle_last) state_d = StConvert;
      StConvert: if (cvt_end && last_rep) state_d = StCapture;
      StCapture: state_d = StGap;
      StGap:     state_d = StSeek;
      default:   state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Datapath: latched config, channel pointer, counters, results and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q      <= '0;
      settle_q    <= '0;
      tmo_q       <= '0;
      ptr_q       <= '0;
      end_q       <= 1'b0;
      set_cnt_q   <= '0;
      cvt_cnt_q   <= '0;
      tmo_flags_q <= '0;
      rd_data_q   <= '0;
      for (int i = 0; i < int'(NCH); i++) res_q[i] <= '0;
    end else begin
      if (start_ok) begin
        mask_q      <= chan_mask_i;
        settle_q    <= settle_i;
        tmo_q       <= timeout_i;
        tmo_flags_q <= '0;
        ptr_q       <= '0;
        end_q       <= 1'b0;
      end
      if (!abort) begin
        case (state_q)
          StSeek: begin
            ptr_q     <= seek_found ? seek_idx : first_idx;
            end_q     <= 1'b0;
            set_cnt_q <= '0;
            cvt_cnt_q <= '0;
          end
          StSettle:  set_cnt_q <= set_cnt_q + SETTLE_W'(1);
          StConvert: cvt_cnt_q <= cvt_end ? '0 : cvt_cnt_q + TMO_W'(1);
          StGap: begin
            if (ptr_q == CW'(NCH - 1)) begin
              ptr_q <= '0;
              end_q <= 1'b1;
            end else begin
              ptr_q <= ptr_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
      if (cvt_end && last_rep) res_q[ptr_q] <= store_val;
      if (cvt_tmo) tmo_flags_q[ptr_q] <= 1'b1;
      rd_data_q <= (int'(rd_ch_i) < int'(NCH)) ? res_q[rd_ch_i] : '0;
    end
  end

  // Outputs.
  always_comb begin
    busy_o      = (state_q != StIdle);
    ramp_en_o   = (state_q == StConvert);
    res_valid_o = (state_q == StCapture);
    res_ch_o    = ptr_q;
    done_o      = (state_q == StSeek) && !seek_found && !continuous_i && !stop_i;
    ramp_clr_o  = abort || cvt_tmo;
    // In SEEK show the channel about to be selected so the mux is stable from SEEK to GAP.
    mux_sel_o   = (state_q == StSeek) ? (seek_found ? seek_idx : first_idx) : ptr_q;
    tmo_flags_o = tmo_flags_q;
    rd_data_o   = rd_data_q;
  end

endmodule

// File: tb/tb_ramp_adc_seq.sv
module tb_ramp_adc_seq;

  localparam int NCH      = 4;
  localparam int NBITS    = 8;
  localparam int SETTLE_W = 8;
  localparam int TMO_W    = 20;
  localparam int CW       = 2;
  localparam int ALL1     = (1 << NBITS) - 1;
`ifdef RAMP_ADC_SEQ_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  logic                start_i = 1'b0;
  logic                stop_i = 1'b0;
  logic                continuous_i = 1'b0;
  logic [NCH-1:0]      chan_mask_i = '0;
  logic [SETTLE_W-1:0] settle_i = '0;
  logic [TMO_W-1:0]    timeout_i = '0;
  logic                ramp_en_o;
  logic                ramp_clr_o;
  logic                ramp_valid_i = 1'b0;
  logic [NBITS-1:0]    ramp_value_i = '0;
  logic [CW-1:0]       mux_sel_o;
  logic [CW-1:0]       rd_ch_i = '0;
  logic [NBITS-1:0]    rd_data_o;
  logic                res_valid_o;
  logic [CW-1:0]       res_ch_o;
  logic [NCH-1:0]      tmo_flags_o;
  logic                busy_o;
  logic                done_o;

  always #5 clk = ~clk;

  ramp_adc_seq #(
    .NCH(NCH), .NBITS(NBITS), .SETTLE_W(SETTLE_W), .TMO_W(TMO_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .chan_mask_i(chan_mask_i), .settle_i(settle_i),
    .timeout_i(timeout_i), .ramp_en_o(ramp_en_o), .ramp_clr_o(ramp_clr_o),
    .ramp_valid_i(ramp_valid_i), .ramp_value_i(ramp_value_i), .mux_sel_o(mux_sel_o),
    .rd_ch_i(rd_ch_i), .rd_data_o(rd_data_o), .res_valid_o(res_valid_o),
    .res_ch_o(res_ch_o), .tmo_flags_o(tmo_flags_o), .busy_o(busy_o), .done_o(done_o)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Ramp core behaviour per channel: valid fires on CONVERT cycle k_arr[ch].
  int               k_arr   [NCH];
  logic [NBITS-1:0] val_arr [NCH][4];
  // Reference model state: stored results and expected timeout flags.
  logic [NBITS-1:0] res_m   [NCH];
  logic [NCH-1:0]   flags_m;

  int   conv_cyc = 0;
  int   conv_no = 0;
  int   te_cur = 1;
  logic fire = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the ramp core model; returns #1 after the falling edge with outputs settled.
  task automatic ramp_step();
    @(negedge clk);
    start_i = 1'b0;
    if (ramp_en_o) begin
      conv_cyc++;
      fire = (conv_cyc == k_arr[mux_sel_o]);
      ramp_valid_i = fire;
      ramp_value_i = val_arr[mux_sel_o][conv_no];
    end else begin
      conv_cyc = 0;
      conv_no = 0;
      fire = 1'b0;
      // Stray valids outside CONVERT must be ignored.
      ramp_valid_i = ($urandom_range(3) == 0);
      ramp_value_i = NBITS'($urandom);
    end
    #1;
    if (ramp_en_o) begin
      check("ramp_clr", ramp_clr_o, (!fire && conv_cyc == te_cur));
      if (fire || conv_cyc == te_cur) begin
        conv_cyc = 0;
        conv_no++;
      end
    end
  endtask

  task automatic run_scan(input logic [NCH-1:0] mask, input int s, input int t);
    int se, te, len, sum, exp_cyc, c, expc;
    int q[$];
    logic [NCH-1:0] fl;
    bit done_seen;
    se = (s == 0) ? 1 : s;
    te = (t == 0) ? 1 : t;
    te_cur = te;
    exp_cyc = 1;
    fl = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        sum = 0;
        len = 0;
        for (int j = 0; j < NCONV; j++) begin
          if (k_arr[ch] <= te) begin
            len += k_arr[ch];
            sum += int'(val_arr[ch][j]);
          end else begin
            len += te;
            sum += ALL1;
            fl[ch] = 1'b1;
          end
        end
        res_m[ch] = NBITS'(sum / NCONV);
        exp_cyc += 3 + se + len;
        q.push_back(ch);
      end
    end
    flags_m = fl;

    @(negedge clk);
    start_i = 1'b1;
    continuous_i = 1'b0;
    chan_mask_i = mask;
    settle_i = SETTLE_W'(s);
    timeout_i = TMO_W'(t);
    c = 0;
    done_seen = 1'b0;
    while (!done_seen && c < exp_cyc + 20) begin
      ramp_step();
      c++;
      // Config is latched; scrambling it mid-scan must have no effect.
      chan_mask_i = NCH'($urandom);
      settle_i = SETTLE_W'($urandom);
      timeout_i = TMO_W'($urandom);
      if (res_valid_o) begin
        expc = (q.size() != 0) ? q.pop_front() : NCH;
        check("res_ch", res_ch_o, expc);
      end
      if (done_o) begin
        done_seen = 1'b1;
        check("done_cycle", c, exp_cyc);
      end
    end
    check("done_seen", done_seen, 1);
    check("res_remaining", q.size(), 0);
    ramp_step();
    check("busy_after", busy_o, 0);
    check("done_single", done_o, 0);
    check("tmo_flags", tmo_flags_o, flags_m);
    for (int ch = 0; ch < NCH; ch++) begin
      @(negedge clk);
      rd_ch_i = CW'(ch);
      @(negedge clk);
      #1;
      check($sformatf("rd_data%0d", ch), rd_data_o, res_m[ch]);
    end
  endtask

  task automatic set_chan(input int ch, input int k, input int v);
    k_arr[ch] = k;
    for (int j = 0; j < 4; j++) val_arr[ch][j] = NBITS'(v);
  endtask

  initial begin
    int seq [4];
    int n, guard;
    logic [NCH-1:0] rmask;
    for (int ch = 0; ch < NCH; ch++) begin
      res_m[ch] = '0;
      set_chan(ch, 1, 0);
    end
    flags_m = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_ramp_en", ramp_en_o, 0);
    check("rst_ramp_clr", ramp_clr_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_mux_sel", mux_sel_o, 0);
    check("rst_tmo_flags", tmo_flags_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Start with empty mask is ignored.
    @(negedge clk);
    start_i = 1'b1;
    chan_mask_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("mask0_busy", busy_o, 0);
    check("mask0_done", done_o, 0);
    @(negedge clk);
    #1;
    check("mask0_busy2", busy_o, 0);

    // Two channels, valid after 20 cycles.
    set_chan(0, 20, 'h5A);
    set_chan(2, 20, 'h5A);
    run_scan(4'b0101, 3, 1000);

    // Timeout on channel 1.
    set_chan(1, 1000, 'h12);
    run_scan(4'b0010, 0, 50);

    // Valid coincides with the last allowed cycle: valid wins.
    set_chan(0, 30, 'h33);
    run_scan(4'b0001, 2, 30);

    // Timeout 0 behaves as 1.
    set_chan(3, 1, 'hC4);
    set_chan(1, 2, 'h77);
    run_scan(4'b1010, 1, 0);

`ifdef RAMP_ADC_SEQ_AVG_EN
    // Averaging: 10, 11, 12, 13 -> 11.
    k_arr[0] = 5;
    for (int j = 0; j < 4; j++) val_arr[0][j] = NBITS'(10 + j);
    run_scan(4'b0001, 1, 20);
`endif

    // Continuous scan 0, 3, 0, 3 with no done, then stop mid-CONVERT.
    set_chan(0, 3, 'h21);
    set_chan(3, 3, 'h43);
    te_cur = 20;
    seq = '{0, 3, 0, 3};
    @(negedge clk);
    start_i = 1'b1;
    continuous_i = 1'b1;
    chan_mask_i = 4'b1001;
    settle_i = SETTLE_W'(1);
    timeout_i = TMO_W'(20);
    n = 0;
    guard = 0;
    while (n < 4 && guard < 300) begin
      ramp_step();
      guard++;
      check("cont_no_done", done_o, 0);
      if (res_valid_o) begin
        check($sformatf("cont_ch%0d", n), res_ch_o, seq[n]);
        n++;
      end
    end
    check("cont_count", n, 4);
    guard = 0;
    while (!ramp_en_o && guard < 50) begin
      ramp_step();
      guard++;
    end
    check("cont_in_convert", ramp_en_o, 1);
    @(negedge clk);
    stop_i = 1'b1;
    ramp_valid_i = 1'b0;
    #1;
    check("stop_clr", ramp_clr_o, 1);
    @(negedge clk);
    stop_i = 1'b0;
    continuous_i = 1'b0;
    #1;
    check("stop_busy", busy_o, 0);
    check("stop_ramp_en", ramp_en_o, 0);
    check("stop_clr_done", ramp_clr_o, 0);
    check("stop_no_done", done_o, 0);

    // Asynchronous reset during CONVERT.
    set_chan(0, 99, 'h11);
    te_cur = 100;
    @(negedge clk);
    start_i = 1'b1;
    chan_mask_i = 4'b0001;
    settle_i = SETTLE_W'(1);
    timeout_i = TMO_W'(100);
    guard = 0;
    while (!ramp_en_o && guard < 20) begin
      ramp_step();
      guard++;
    end
    check("pre_rst_convert", ramp_en_o, 1);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_ramp_en", ramp_en_o, 0);
    check("arst_ramp_clr", ramp_clr_o, 0);
    check("arst_res_valid", res_valid_o, 0);
    check("arst_done", done_o, 0);
    check("arst_mux_sel", mux_sel_o, 0);
    check("arst_res_ch", res_ch_o, 0);
    check("arst_tmo_flags", tmo_flags_o, 0);
    check("arst_rd_data", rd_data_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    ramp_valid_i = 1'b0;
    for (int ch = 0; ch < NCH; ch++) res_m[ch] = '0;

    // Randomized scans.
    for (int r = 0; r < 8; r++) begin
      rmask = NCH'($urandom_range(1, 15));
      for (int ch = 0; ch < NCH; ch++) begin
        k_arr[ch] = $urandom_range(1, 35);
        for (int j = 0; j < 4; j++) val_arr[ch][j] = NBITS'($urandom);
      end
      run_scan(rmask, $urandom_range(0, 4), $urandom_range(0, 30));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
